// File: rtl/dio24_bus_timing.sv
// dio24_bus_timing: bus output timing stage. Holds one 64-bit sample
// {data[31:0], time[31:0]}, runs a board time counter at clk_bus/clk_div and
// drives the rack bus when the board time reaches the sample time.
//
// Stream handshake: a sample transfers on every cycle where in_valid and
// in_ready are both 1. in_valid may not depend on in_ready. in_ready is
// (!hold_valid || consume), and only in IDLE or RUN. This lets the next
// sample load on the same cycle the held one is consumed.
module dio24_bus_timing #(
  parameter int BUS_DATA_BITS   = 16,
  parameter int BUS_ADDR_BITS   = 7,
  parameter int CLK_DIV_BITS    = 8,
  parameter int STRB_DELAY_BITS = 8,
  parameter int BIT_NOP         = 31,
  parameter int BIT_IRQ         = 29,
  parameter int BIT_STOP        = 28
) (
  input  logic                       clk_bus,
  input  logic                       reset_bus,
  input  logic                       run_en,
  input  logic                       trg_start,
  input  logic [CLK_DIV_BITS-1:0]    clk_div,
  input  logic [STRB_DELAY_BITS-1:0] strb_delay,
  input  logic [STRB_DELAY_BITS-1:0] strb_len,
  input  logic [31:0]                num_samples,
  input  logic [63:0]                in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [BUS_DATA_BITS-1:0]   bus_data,
  output logic [BUS_ADDR_BITS-1:0]   bus_addr,
  output logic                       bus_strb,
  output logic                       bus_en,
  output logic [31:0]                board_time,
  output logic [31:0]                sample_count,
  output logic                       status_run,
  output logic                       status_end,
  output logic                       error_time,
  output logic                       irq_data,
  output logic [2:0]                 dbg_state
);

  // Common width for comparing the divider count with the strobe window.
  localparam int CW = ((CLK_DIV_BITS > STRB_DELAY_BITS) ? CLK_DIV_BITS : STRB_DELAY_BITS) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_END   = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [CLK_DIV_BITS-1:0]  div_cnt_q, div_cnt_d;
  logic [31:0]              board_time_q, board_time_d;
  logic [31:0]              sample_count_q, sample_count_d;
  logic [63:0]              hold_q, hold_d;
  logic                     hold_valid_q, hold_valid_d;
  logic [BUS_DATA_BITS-1:0] bus_data_q, bus_data_d;
  logic [BUS_ADDR_BITS-1:0] bus_addr_q, bus_addr_d;
  logic                     bus_strb_q, bus_strb_d;
  logic                     strb_arm_q, strb_arm_d;
  logic                     error_time_q, error_time_d;
  logic                     status_end_q, status_end_d;
  logic                     irq_q, irq_d;

  logic [31:0]   hold_time;
  logic [31:0]   hold_word;
  logic          period_start, tick, check, consume, late, end_hit;
  logic          load_ok, ready_int, out_en, strb_state_ok;
  logic [CW-1:0] div_ext, strb_lo, strb_hi;
  logic          unused_hold_bits;

  assign hold_time = hold_q[31:0];
  assign hold_word = hold_q[63:32];
  // Not every data bit maps to a bus field or control flag.
  assign unused_hold_bits = ^hold_word;

  // Next-state, match check, counters and registered bus outputs.
  always_comb begin
    state_d        = state_q;
    div_cnt_d      = div_cnt_q;
    board_time_d   = board_time_q;
    sample_count_d = sample_count_q;
    hold_d         = hold_q;
    hold_valid_d   = hold_valid_q;
    bus_data_d     = bus_data_q;
    bus_addr_d     = bus_addr_q;
    bus_strb_d     = 1'b0;
    strb_arm_d     = strb_arm_q;
    error_time_d   = error_time_q;
    status_end_d   = status_end_q;
    irq_d          = 1'b0;

    div_ext      = CW'(div_cnt_q);
    strb_lo      = CW'(strb_delay);
    strb_hi      = CW'(strb_delay) + CW'(strb_len);
    period_start = (div_cnt_q == '0);
    tick         = (div_ext + CW'(1)) >= CW'(clk_div);

    // The sample is compared once per bus period, at its first cycle.
    check   = run_en && (state_q == S_RUN) && period_start && hold_valid_q;
    consume = check && (hold_time == board_time_q);
    late    = check && (hold_time < board_time_q);
    end_hit = consume && ((sample_count_q + 32'd1) == num_samples);
    out_en  = consume && !hold_word[BIT_NOP];

    load_ok   = (state_q == S_IDLE) || (state_q == S_RUN);
    ready_int = load_ok && (!hold_valid_q || consume);

    if (in_valid && ready_int) begin
      hold_d       = in_data;
      hold_valid_d = 1'b1;
    end else if (consume) begin
      hold_valid_d = 1'b0;
    end

    if (consume) begin
      sample_count_d = sample_count_q + 32'd1;
      irq_d          = hold_word[BIT_IRQ] || end_hit;
    end

    if (out_en) begin
      bus_data_d = hold_word[BUS_DATA_BITS-1:0];
      bus_addr_d = hold_word[16 +: BUS_ADDR_BITS];
    end

    // Time keeps running after the last sample so its strobe can finish.
    if ((state_q == S_RUN) || (state_q == S_END)) begin
      if (tick) begin
        div_cnt_d    = '0;
        board_time_d = board_time_q + 32'd1;
      end else begin
        div_cnt_d = div_cnt_q + CLK_DIV_BITS'(1);
      end
    end

    case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN: begin
        if (late) begin
          state_d      = S_ERROR;
          error_time_d = 1'b1;
        end else if (end_hit) begin
          state_d      = S_END;
          status_end_d = 1'b1;
        end else if (consume && hold_word[BIT_STOP]) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (trg_start) begin
          state_d   = S_RUN;
          div_cnt_d = '0;
        end
      end
      default: ;
    endcase

    if (!run_en) begin
      state_d        = S_IDLE;
      div_cnt_d      = '0;
      board_time_d   = '0;
      sample_count_d = '0;
      error_time_d   = 1'b0;
      status_end_d   = 1'b0;
    end

    // The strobe arm is latched at the match and lasts for that period.
    if (period_start) begin
      strb_arm_d = out_en;
    end
    strb_state_ok = ((state_q == S_RUN) || (state_q == S_END)) &&
                    ((state_d == S_RUN) || (state_d == S_END));
    // Registered one cycle ahead, so high while div_cnt is in [delay+1, delay+len].
    bus_strb_d = strb_state_ok && (period_start ? out_en : strb_arm_q) &&
                 (div_ext >= strb_lo) && (div_ext < strb_hi);
  end

  // State and datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clk_bus or posedge reset_bus) begin
    if (reset_bus) begin
      state_q        <= S_IDLE;
      div_cnt_q      <= '0;
      board_time_q   <= '0;
      sample_count_q <= '0;
      hold_q         <= '0;
      hold_valid_q   <= 1'b0;
      bus_data_q     <= '0;
      bus_addr_q     <= '0;
      bus_strb_q     <= 1'b0;
      strb_arm_q     <= 1'b0;
      error_time_q   <= 1'b0;
      status_end_q   <= 1'b0;
      irq_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      div_cnt_q      <= div_cnt_d;
      board_time_q   <= board_time_d;
      sample_count_q <= sample_count_d;
      hold_q         <= hold_d;
      hold_valid_q   <= hold_valid_d;
      bus_data_q     <= bus_data_d;
      bus_addr_q     <= bus_addr_d;
      bus_strb_q     <= bus_strb_d;
      strb_arm_q     <= strb_arm_d;
      error_time_q   <= error_time_d;
      status_end_q   <= status_end_d;
      irq_q          <= irq_d;
    end
  end

  // in_ready is forced low while reset is asserted so every output reads 0.
  assign in_ready     = ready_int && !reset_bus;
  assign bus_data     = bus_data_q;
  assign bus_addr     = bus_addr_q;
  assign bus_strb     = bus_strb_q;
  assign bus_en       = (state_q == S_RUN) || (state_q == S_PAUSE) || (state_q == S_END);
  assign board_time   = board_time_q;
  assign sample_count = sample_count_q;
  assign status_run   = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign status_end   = status_end_q;
  assign error_time   = error_time_q;
  assign irq_data     = irq_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dio24_bus_timing.sv
// Directed bench for dio24_bus_timing: sequence output, NOP/IRQ, stop and
// resume, late sample error, async reset mid-strobe, full-rate backpressure.
module tb_dio24_bus_timing;

  logic        clk_bus;
  logic        reset_bus;
  logic        run_en;
  logic        trg_start;
  logic [7:0]  clk_div;
  logic [7:0]  strb_delay;
  logic [7:0]  strb_len;
  logic [31:0] num_samples;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bus_data;
  logic [6:0]  bus_addr;
  logic        bus_strb;
  logic        bus_en;
  logic [31:0] board_time;
  logic [31:0] sample_count;
  logic        status_run;
  logic        status_end;
  logic        error_time;
  logic        irq_data;
  logic [2:0]  dbg_state;

  int n_total = 0;
  int n_pass  = 0;
  int irq_cnt = 0;
  int rise_cnt = 0;
  int irq_base = 0;
  logic mon_en = 1'b0;
  logic strb_prev = 1'b0;

  logic [63:0] feed_q[$];
  logic [22:0] exp_q[$];

  dio24_bus_timing dut (
    .clk_bus      (clk_bus),
    .reset_bus    (reset_bus),
    .run_en       (run_en),
    .trg_start    (trg_start),
    .clk_div      (clk_div),
    .strb_delay   (strb_delay),
    .strb_len     (strb_len),
    .num_samples  (num_samples),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .bus_data     (bus_data),
    .bus_addr     (bus_addr),
    .bus_strb     (bus_strb),
    .bus_en       (bus_en),
    .board_time   (board_time),
    .sample_count (sample_count),
    .status_run   (status_run),
    .status_end   (status_end),
    .error_time   (error_time),
    .irq_data     (irq_data),
    .dbg_state    (dbg_state)
  );

  // Clock
  initial begin
    clk_bus = 1'b0;
    forever #5 clk_bus = ~clk_bus;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_bus);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Starts on a div_cnt==0 cycle; checks the bus value and strobe over one 10-cycle period.
  task automatic period_check(input string tag, input logic [15:0] ed, input logic [6:0] ea,
                              input int en);
    int cnt;
    int first;
    cnt = 0;
    first = -1;
    tick(1);
    chk({tag, "_data"}, bus_data, ed);
    chk({tag, "_addr"}, bus_addr, ea);
    for (int k = 1; k <= 10; k++) begin
      if (bus_strb) begin
        cnt++;
        if (first < 0) first = k;
      end
      if (k < 10) tick(1);
    end
    chk({tag, "_strb_len"}, 64'(cnt), 64'(en));
    if (en > 0) chk({tag, "_strb_pos"}, 64'(first), 64'd3);
  endtask

  // Stream driver: presents feed_q head, pops it after each accepted transfer.
  initial begin
    logic feed_xfer;
    in_valid = 1'b0;
    in_data  = '0;
    forever begin
      @(negedge clk_bus);
      #2;
      feed_xfer = in_valid && in_ready;
      @(posedge clk_bus);
      #1;
      if (feed_xfer) void'(feed_q.pop_front());
      if (feed_q.size() != 0) begin
        in_valid = 1'b1;
        in_data  = feed_q[0];
      end else begin
        in_valid = 1'b0;
      end
    end
  end

  // irq pulse counter
  always @(negedge clk_bus) begin
    if (irq_data) irq_cnt++;
  end

  // Scoreboard for the backpressure run: one bus word per strobe rising edge.
  always @(negedge clk_bus) begin
    if (mon_en && bus_strb && !strb_prev) begin
      rise_cnt++;
      chk("bp_have_exp", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("bp_bus", {bus_addr, bus_data}, exp_q.pop_front());
    end
    strb_prev = bus_strb;
  end

  initial begin
    reset_bus   = 1'b1;
    run_en      = 1'b0;
    trg_start   = 1'b0;
    clk_div     = 8'd10;
    strb_delay  = 8'd2;
    strb_len    = 8'd4;
    num_samples = 32'd3;

    // Reset values
    tick(2);
    chk("rst_state", dbg_state, 3'd0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_flags", {bus_strb, bus_en, status_run, status_end, error_time, irq_data}, 6'd0);
    chk("rst_time", board_time, 32'd0);
    reset_bus = 1'b0;

    // Sequence output: times 0, 1, 5
    feed_q.push_back({32'h0001_0011, 32'd0});
    feed_q.push_back({32'h0002_0022, 32'd1});
    feed_q.push_back({32'h0003_0033, 32'd5});
    tick(4);
    chk("seq_prefetch_ready", in_ready, 1'b0);
    chk("seq_idle", dbg_state, 3'd0);
    irq_base = irq_cnt;
    run_en = 1'b1;
    tick(1);
    chk("seq_run_state", dbg_state, 3'd1);
    chk("seq_run_time", board_time, 32'd0);
    chk("seq_status_run", {status_run, bus_en}, 2'b11);
    chk("seq_ready_consume", in_ready, 1'b1);
    period_check("seq_p0", 16'h0011, 7'h01, 4);
    period_check("seq_p1", 16'h0022, 7'h02, 4);
    chk("seq_time2", board_time, 32'd2);
    for (int p = 2; p < 5; p++) period_check("seq_gap", 16'h0022, 7'h02, 0);
    period_check("seq_p5", 16'h0033, 7'h03, 4);
    chk("seq_end", status_end, 1'b1);
    chk("seq_count", sample_count, 32'd3);
    chk("seq_end_state", dbg_state, 3'd3);
    chk("seq_end_ready", in_ready, 1'b0);
    chk("seq_irq", 64'(irq_cnt), 64'(irq_base + 1));
    run_en = 1'b0;
    tick(1);
    chk("seq_clear_flags", {status_end, status_run, bus_en}, 3'd0);
    chk("seq_clear_cnt", {board_time, sample_count}, 64'd0);
    chk("seq_bus_kept", bus_data, 16'h0033);

    // NOP and IRQ
    num_samples = 32'd4;
    feed_q.push_back({32'h0004_0044, 32'd0});
    feed_q.push_back({32'h8005_0055, 32'd1});
    feed_q.push_back({32'h2006_0066, 32'd2});
    feed_q.push_back({32'h0007_0077, 32'd3});
    tick(4);
    irq_base = irq_cnt;
    run_en = 1'b1;
    tick(1);
    period_check("nop_p0", 16'h0044, 7'h04, 4);
    period_check("nop_p1", 16'h0044, 7'h04, 0);
    chk("nop_count", sample_count, 32'd2);
    chk("nop_no_irq", 64'(irq_cnt), 64'(irq_base));
    period_check("irq_p2", 16'h0066, 7'h06, 4);
    chk("irq_one_pulse", 64'(irq_cnt), 64'(irq_base + 1));
    period_check("irq_p3", 16'h0077, 7'h07, 4);
    chk("irq_end_pulse", 64'(irq_cnt), 64'(irq_base + 2));
    chk("irq_end", status_end, 1'b1);
    run_en = 1'b0;
    tick(1);

    // Stop bit at time 3, resume on trg_start
    num_samples = 32'd2;
    feed_q.push_back({32'h1008_0088, 32'd3});
    feed_q.push_back({32'h0009_0099, 32'd4});
    tick(4);
    run_en = 1'b1;
    tick(1);
    tick(31);
    chk("stop_bus", {bus_addr, bus_data}, {7'h08, 16'h0088});
    chk("stop_state", dbg_state, 3'd2);
    chk("stop_count", sample_count, 32'd1);
    tick(2);
    chk("stop_no_strb", bus_strb, 1'b0);
    tick(3);
    chk("stop_time_frozen", board_time, 32'd3);
    chk("stop_ready", in_ready, 1'b0);
    chk("stop_status_run", status_run, 1'b1);
    trg_start = 1'b1;
    tick(1);
    trg_start = 1'b0;
    chk("resume_state", dbg_state, 3'd1);
    chk("resume_time", board_time, 32'd3);
    period_check("resume_wait", 16'h0088, 7'h08, 0);
    chk("resume_time4", board_time, 32'd4);
    tick(1);
    chk("resume_bus", {bus_addr, bus_data}, {7'h09, 16'h0099});
    chk("resume_end", status_end, 1'b1);
    tick(3);
    chk("cut_strb_before", bus_strb, 1'b1);
    run_en = 1'b0;
    tick(1);
    chk("cut_strb_after", bus_strb, 1'b0);
    chk("cut_state", dbg_state, 3'd0);

    // Late sample: time 5 arrives after board_time reached 7
    num_samples = 32'd10;
    run_en = 1'b1;
    tick(1);
    tick(70);
    chk("late_time7", board_time, 32'd7);
    chk("late_ready_empty", in_ready, 1'b1);
    feed_q.push_back({32'h000A_00AA, 32'd5});
    tick(11);
    chk("late_error", error_time, 1'b1);
    chk("late_state", dbg_state, 3'd4);
    chk("late_ready", in_ready, 1'b0);
    chk("late_flags", {status_run, bus_en}, 2'b00);
    begin
      int scnt;
      scnt = 0;
      for (int k = 0; k < 10; k++) begin
        if (bus_strb) scnt++;
        tick(1);
      end
      chk("late_no_strb", 64'(scnt), 64'd0);
    end
    chk("late_bus_held", bus_data, 16'h0099);
    run_en = 1'b0;
    tick(1);
    chk("late_clear", error_time, 1'b0);
    chk("late_idle", dbg_state, 3'd0);

    // Async reset mid-strobe (held time-5 sample is output at period 5)
    run_en = 1'b1;
    tick(1);
    tick(54);
    chk("arst_strb_pre", bus_strb, 1'b1);
    chk("arst_bus_pre", {bus_addr, bus_data}, {7'h0A, 16'h00AA});
    #3;
    reset_bus = 1'b1;
    run_en    = 1'b0;
    #1;
    chk("arst_flags", {bus_strb, bus_en, status_run, status_end, error_time, irq_data, in_ready}, 7'd0);
    chk("arst_bus", {bus_addr, bus_data}, 23'd0);
    chk("arst_cnt", {board_time, sample_count}, 64'd0);
    chk("arst_state", dbg_state, 3'd0);
    tick(1);
    reset_bus = 1'b0;
    tick(1);
    chk("arst_hold_empty", in_ready, 1'b1);

    // Backpressure: 100 samples at consecutive times, full rate
    clk_div     = 8'd4;
    strb_delay  = 8'd0;
    strb_len    = 8'd3;
    num_samples = 32'd100;
    for (int i = 0; i < 100; i++) begin
      logic [31:0] w;
      w = {9'd0, 7'(i), 16'(16'h0100 + i)};
      feed_q.push_back({w, 32'(i)});
      exp_q.push_back(w[22:0]);
    end
    mon_en = 1'b1;
    tick(3);
    run_en = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if (status_end) break;
      tick(1);
    end
    chk("bp_end", status_end, 1'b1);
    tick(6);
    mon_en = 1'b0;
    chk("bp_count", sample_count, 32'd100);
    chk("bp_strobes", 64'(rise_cnt), 64'd100);
    chk("bp_exp_left", 64'(exp_q.size()), 64'd0);
    run_en = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dio24_bus_timing.md
# dio24_bus_timing

Bus output timing stage for dio24 experiment control. It sits directly downstream of the TX stream path and consumes 64-bit samples `{data[31:0], time[31:0]}`. It runs a board time counter at `clk_bus/clk_div` and drives the rack bus (data, address, strobe) when the board time equals the sample time. It also reports run status, sample count, end-of-sequence and timing errors to the control register block.

## Interface
Parameters:
- `BUS_DATA_BITS`, 16: bus data width; mapped from `data[15:0]`.
- `BUS_ADDR_BITS`, 7: bus address width; mapped from `data[22:16]`.
- `CLK_DIV_BITS`, 8: width of `clk_div`.
- `STRB_DELAY_BITS`, 8: width of `strb_delay` and `strb_len`.
- `BIT_NOP`, 31: data bit that suppresses bus output; time still runs.
- `BIT_IRQ`, 29: data bit that produces an `irq_data` pulse when the sample is output.
- `BIT_STOP`, 28: data bit that pauses the sequence after the sample is output, until `trg_start`.

Ports (clock and reset first):
- `clk_bus` in 1: single clock for the whole block.
- `reset_bus` in 1: asynchronous, active-high reset.
- `run_en` in 1: run enable from the control register; level.
- `trg_start` in 1: single-cycle resume pulse, already synchronized to `clk_bus`.
- `clk_div` in 8: bus clock divider; legal range 4..255.
- `strb_delay` in 8: strobe rise position within the period.
- `strb_len` in 8: strobe high length; `strb_delay + strb_len <= clk_div - 1`.
- `num_samples` in 32: number of samples in the sequence; must be >= 1.
- `in_data` in 64: sample; `[31:0]` is time, `[63:32]` is data.
- `in_valid` in 1: AXI-stream valid.
- `in_ready` out 1: AXI-stream ready.
- `bus_data` out 16, `bus_addr` out 7, `bus_strb` out 1, `bus_en` out 1: rack bus outputs.
- `board_time` out 32: current board time in bus periods.
- `sample_count` out 32: number of samples consumed.
- `status_run` out 1, `status_end` out 1, `error_time` out 1: status flags.
- `irq_data` out 1: one-cycle pulse.

## Operation
- The holding register `hold` has a valid flag.
  - Handshake: `in_ready = !hold_valid || consume`, where `consume` is the match event defined below.
  - A transfer happens on any cycle where `in_valid && in_ready`.
  - Loading is allowed in IDLE and RUN, so the first sample can be prefetched. `in_ready` is 0 in PAUSE, END and ERROR.
- `div_cnt` counts 0..`clk_div`-1 in RUN. The tick is `div_cnt == clk_div-1`, and `board_time` increments on each tick.
- Match check, at `div_cnt == 0` in RUN with `hold_valid`:
  - If `hold.time == board_time`, consume the sample and increment `sample_count`.
  - If `BIT_NOP` = 0, register `bus_data` and `bus_addr` from `hold.data` and raise the strobe in this period.
  - If `BIT_IRQ` = 1, pulse `irq_data`.
  - If `hold.time < board_time`, enter ERROR: `error_time` = 1, bus outputs are held and the strobe is 0.
  - If `hold_valid` = 0 at the check, nothing is output and time keeps running (no underflow error).
- State machine:
  - IDLE → RUN on `run_en` = 1.
  - RUN → PAUSE after consuming a sample with `BIT_STOP` = 1. In PAUSE, `div_cnt` and `board_time` are frozen and `bus_strb` is 0.
  - PAUSE → RUN on `trg_start`; `div_cnt` restarts at 0.
  - RUN → END when `sample_count` reaches `num_samples`. END takes priority over PAUSE on the same sample. `status_end` = 1 and `irq_data` pulses once on entry.
  - Any state → IDLE when `run_en` = 0. This clears `div_cnt`, `board_time`, `sample_count`, `error_time` and `status_end`. `hold` and the bus outputs are kept.
- `status_run` = 1 in RUN and PAUSE. `bus_en` = 1 in RUN, PAUSE and END.
- Arithmetic: `board_time` and `sample_count` are unsigned 32-bit. `board_time` wraps from 0xFFFF_FFFF to 0 without raising an error.

## Timing
- Reset values: all outputs 0, state IDLE, `hold_valid` = 0.
- RUN entry: `run_en` rising at cycle N gives `div_cnt` = 0 and `board_time` = 0 at cycle N+1.
- Bus update: when a match is evaluated at cycle C (`div_cnt` = 0), `bus_data` and `bus_addr` change at C+1 and are stable for the whole period.
- Strobe: `bus_strb` = 1 for `div_cnt` in `[strb_delay+1, strb_delay+strb_len]` of the matched period. It is registered and comes from the same flop bank as `bus_data`.
- Back-to-back samples: a sample accepted on the consume cycle is eligible for the next period's match. Samples at consecutive times can therefore be output at full rate.
- `irq_data`: asserted at C+1 for exactly one cycle.
- `status_end`: asserted at C+1 after the last consume.
- `run_en` falling mid-period: a strobe in progress is cut to 0 on the next cycle.

## Test plan
- Sequence output: `clk_div` = 10, `strb_delay` = 2, `strb_len` = 4, samples at times 0, 1, 5 with data 0x0001_0011, 0x0002_0022, 0x0003_0033.
  - Required: bus updates at periods 0, 1 and 5 (cycles 1, 11, 51 after RUN entry), strobe high 4 cycles in each, `status_end` after the 3rd sample.
- NOP and IRQ: sample with `BIT_NOP` set.
  - Required: bus unchanged, no strobe, `sample_count` increments.
  - A sample with `BIT_IRQ` set gives exactly one `irq_data` pulse.
- Stop bit: sample 1 at time 3 with `BIT_STOP` set.
  - Required: `board_time` frozen at 3 and `in_ready` = 0.
  - A `trg_start` pulse resumes RUN; the next sample at time 4 is output one period later.
- Late sample: stall `in_valid` until `board_time` = 7, then send a sample with time 5.
  - Required: `error_time` = 1, no strobe, `in_ready` = 0.
  - `run_en` low clears the error.
- Backpressure: hold `in_valid` = 1 with times 0..99 and `num_samples` = 100.
  - Required: no sample lost or duplicated, `sample_count` = 100, END reached.
- Async reset: assert `reset_bus` mid-strobe.
  - Required: all outputs 0 immediately, state IDLE.
